// File: rtl/pwm_pkg.sv
// Shared constants for the PWM output stage.
// Register addresses match the spi_peripheral register map so both sides
// agree on where each configuration byte lives.
package pwm_pkg;

  localparam int          PWM_CNT_W       = 8;
  localparam logic [7:0]  DUTY_FULL       = 8'hFF;
  localparam int          CLK_DIV_DEFAULT = 13;
  localparam int          PWM_PINS        = 16;

  typedef enum logic [7:0] {
    REG_EN_OUT_7_0  = 8'h00,
    REG_EN_OUT_15_8 = 8'h01,
    REG_EN_PWM_7_0  = 8'h02,
    REG_EN_PWM_15_8 = 8'h03,
    REG_PWM_DUTY    = 8'h04
  } reg_addr_e;

  // Full scale is a special case: a plain compare would leave the pin low
  // for the last tick of every period.
  function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                     input logic [PWM_CNT_W-1:0] duty);
    if (duty == DUTY_FULL) return 1'b1;
    return (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_output_stage_if.sv
// Configuration bus from the SPI register file into the PWM output stage.
//   en_reg_out_7_0 / en_reg_out_15_8 : per-pin output enable
//   en_reg_pwm_7_0 / en_reg_pwm_15_8 : per-pin PWM select
//   pwm_duty_cycle                   : requested duty (double-buffered downstream)
// master = register file side, slave = PWM output stage.
interface pwm_output_stage_if;
  import pwm_pkg::*;

  logic [7:0]           en_reg_out_7_0;
  logic [7:0]           en_reg_out_15_8;
  logic [7:0]           en_reg_pwm_7_0;
  logic [7:0]           en_reg_pwm_15_8;
  logic [PWM_CNT_W-1:0] pwm_duty_cycle;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8,
    output en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle
  );

  modport slave (
    input en_reg_out_7_0, en_reg_out_15_8,
    input en_reg_pwm_7_0, en_reg_pwm_15_8,
    input pwm_duty_cycle
  );

endinterface

// File: rtl/pwm_output_stage_timebase.sv
// PWM timebase: prescaler, 8-bit PWM counter and period strobe.
//   clk, rst_n      : clock, asynchronous active-low reset
//   cnt_o           : current PWM counter value
//   boundary_o      : last clk of the period (tick on count 255), combinational
//   period_start_o  : registered one-clk strobe on the first clk of each period
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PWM_CNT_W-1:0] cnt_o,
  output logic                 boundary_o,
  output logic                 period_start_o
);

  logic [7:0]           presc_q, presc_d;
  logic [PWM_CNT_W-1:0] cnt_q, cnt_d;
  logic                 first_q;
  logic                 period_start_q, period_start_d;
  logic                 tick;

  assign tick       = (presc_q == 8'(CLK_DIV - 1));
  assign boundary_o = tick && (cnt_q == '1);

  always_comb begin
    presc_d        = tick ? 8'd0 : presc_q + 8'd1;
    cnt_d          = tick ? cnt_q + 1'b1 : cnt_q;
    // first_q marks the period that begins at reset release
    period_start_d = boundary_o | first_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      first_q        <= 1'b1;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      first_q        <= 1'b0;
      period_start_q <= period_start_d;
    end
  end

  assign cnt_o          = cnt_q;
  assign period_start_o = period_start_q;

endmodule

// File: rtl/pwm_output_stage.sv
// PWM output stage: drives 16 pins as off, static high or a shared PWM
// waveform, from the configuration registers written over SPI.
//   clk, rst_n    : clock, asynchronous active-low reset
//   cfg           : configuration bus (slave modport)
//   out           : registered pin drive, out[7:0]->uo_out, out[15:8]->uio_out
//   period_start  : one-clk strobe on the first clk of each PWM period
// The duty is shadowed at the period boundary so a mid-period write can
// never shorten or stretch the pulse in flight.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int DUTY_W  = PWM_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_output_stage_if.slave   cfg,
  output logic [PWM_PINS-1:0] out,
  output logic                period_start
);

  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic                 boundary;
  logic [DUTY_W-1:0]    duty_shadow_q, duty_shadow_d;
  logic [PWM_PINS-1:0]  out_q, out_d;
  logic [PWM_PINS-1:0]  en_out, en_pwm;
  logic                 pwm_lvl;

  pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
    .clk            (clk),
    .rst_n          (rst_n),
    .cnt_o          (pwm_cnt),
    .boundary_o     (boundary),
    .period_start_o (period_start)
  );

  assign en_out  = {cfg.en_reg_out_15_8, cfg.en_reg_out_7_0};
  assign en_pwm  = {cfg.en_reg_pwm_15_8, cfg.en_reg_pwm_7_0};
  assign pwm_lvl = pwm_level(pwm_cnt, duty_shadow_q);

  always_comb begin
    // shadow loads on the same edge the counter wraps to 0
    duty_shadow_d = boundary ? cfg.pwm_duty_cycle : duty_shadow_q;
    // disabled pins are 0; enabled pins are 1 unless PWM-selected
    out_d         = en_out & (~en_pwm | {PWM_PINS{pwm_lvl}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow_q <= '0;
      out_q         <= '0;
    end else begin
      duty_shadow_q <= duty_shadow_d;
      out_q         <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
module tb_pwm_output_stage;
  import pwm_pkg::*;

  localparam int CD = 13;
  localparam int P  = CD * 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] en_out, en_pwm;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        period_start;

  always #50 clk = ~clk;

  pwm_output_stage_if bus();
  assign bus.en_reg_out_7_0  = en_out[7:0];
  assign bus.en_reg_out_15_8 = en_out[15:8];
  assign bus.en_reg_pwm_7_0  = en_pwm[7:0];
  assign bus.en_reg_pwm_15_8 = en_pwm[15:8];
  assign bus.pwm_duty_cycle  = duty;

  pwm_output_stage #(.CLK_DIV(CD), .DUTY_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg          (bus),
    .out          (out),
    .period_start (period_start)
  );

  typedef struct {
    logic [15:0] o;
    logic        ps;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   n = 0;       // clock edges since reset release
  int   shadow = 0;  // duty in force for the current period

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state derived arithmetically from the edge count.
  always @(posedge clk) begin
    exp_t e;
    int   cnt;
    int   high_ticks;
    bit   lvl;
    if (!rst_n) begin
      n      = 0;
      shadow = 0;
      e.o    = '0;
      e.ps   = 1'b0;
    end else begin
      n++;
      cnt        = ((n - 1) / CD) % 256;
      high_ticks = (shadow == 255) ? 256 : shadow;
      lvl        = (cnt < high_ticks);
      for (int i = 0; i < 16; i++)
        e.o[i] = en_out[i] & (~en_pwm[i] | lvl);
      e.ps = (n == 1) || (n % P == 0);
      if (n % P == 0) shadow = duty;
    end
    q.push_back(e);
  end

  // Monitor
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("out", out, e.o);
      check("period_start", {15'd0, period_start}, {15'd0, e.ps});
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Advance to the negedge where the counter has just become c (prescaler 0).
  task automatic wait_cnt(input int c);
    int guard = 0;
    @(negedge clk);
    while (!((((n / CD) % 256) == c) && ((n % CD) == 0)) && guard < P + 16) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= P + 16) begin
      compared++;
      mismatched++;
      $display("FAIL wait_cnt(%0d): timeout got n=%0d required cnt=%0d", c, n, c);
    end
  endtask

  initial begin
    int hi;
    int t;
    // reset values with all inputs high
    rst_n  = 1'b0;
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'hFF;
    cyc(3);
    check("reset_out", out, 16'h0000);
    check("reset_ps", {15'd0, period_start}, 16'd0);
    rst_n = 1'b1;

    // static outputs
    cyc(5);
    en_pwm = 16'h0000;
    cyc(5);
    en_out = 16'h00F0;
    cyc(5);

    // 50% duty
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'h80;
    wait_cnt(0);
    hi = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      if (out[0]) hi++;
    end
    check("high_clks_50pct", 16'(hi), 16'd1664);

    // duty extremes
    duty = 8'h00;
    wait_cnt(0);
    cyc(P + 100);
    duty = 8'hFF;
    wait_cnt(0);
    cyc(3 * P);

    // mid-period update
    duty = 8'h40;
    wait_cnt(0);
    wait_cnt(8'h20);
    duty = 8'hC0;
    wait_cnt(0);

    // reset mid-operation with output high
    wait_cnt(8'h50);
    check("pre_reset_high", out, 16'hFFFF);
    rst_n = 1'b0;
    #1;
    check("async_reset_out", out, 16'h0000);
    check("async_reset_ps", {15'd0, period_start}, 16'd0);
    cyc(2);
    duty  = 8'h80;
    rst_n = 1'b1;
    cyc(100);
    check("first_period_low", out, 16'h0000);
    wait_cnt(0);
    cyc(16 * CD);
    check("second_period_high", out, 16'hFFFF);

    // randomized enables and duty writes
    t = 0;
    while (t < 2 * P) begin
      int k;
      k = $urandom_range(1, 400);
      cyc(k);
      t += k;
      case ($urandom_range(0, 2))
        0:       en_out = 16'($urandom);
        1:       en_pwm = 16'($urandom);
        default: duty   = 8'($urandom);
      endcase
    end

    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
